mul_result_collector: RTL

Downstream companion of the pipelined FP32 multiplier. It tracks each issued operation through the multiplier's fixed pipeline latency and drives the multiplier's `Enable`. It captures the packed result and exception flags into a small FIFO and presents them to the consumer with a valid/ready handshake. Issue is gated by a credit count so the FIFO can never overflow and no multiplier result is lost.

---
 rtl/mul_result_collector.sv | 105 ++++++++++
 1 files changed

// File: rtl/mul_result_collector.sv
// rtl/mul_result_collector.sv - issue credit, latency tracker and result FIFO for the pipelined FP32 multiplier
// Optional sticky exception status register is enabled by defining MUL_STATUS_STICKY_EN.
module mul_result_collector #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        issue_valid,
    output logic        issue_ready,
    output logic        mul_enable,
    input  logic [22:0] Mz,
    input  logic [7:0]  Ez,
    input  logic        Sz,
    input  logic [4:0]  flags_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_flags,
    output logic [4:0]  status_flags,
    input  logic        status_clr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [36:0]        mem_q [DEPTH];
    logic [36:0]        mem_d [DEPTH];
    logic               accept;
    logic               push;
    logic               pop;

    // Credit is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign issue_ready = (occ_q < CW'(DEPTH));
    assign accept      = issue_valid && issue_ready && !RST;
    assign mul_enable  = accept;
    assign push        = vld_q[LATENCY-1];
    assign res_valid   = (cnt_q != '0);
    assign pop         = res_valid && res_ready;

    assign {res_flags, res_data} = res_valid ? mem_q[rd_ptr_q] : 37'd0;

    always_comb begin
        vld_d    = (vld_q << 1) | LATENCY'(accept);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        occ_d    = occ_q + CW'(accept) - CW'(pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {flags_in, Sz, Ez, Mz};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: the outputs are masked whenever the count is zero.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

`ifdef MUL_STATUS_STICKY_EN
    logic [4:0] status_q, status_d;

    always_comb begin
        status_d = status_clr ? 5'b0 : status_q;
        if (pop) begin
            status_d = status_d | res_flags;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_flags = status_q;
`else
    logic unused_status_clr;
    assign unused_status_clr = status_clr;
    assign status_flags      = 5'b0;
`endif

endmodule
